// File: rtl/global_buffer_dp.sv
// global_buffer_dp: dual-port word SRAM with byte enables, RD_LAT-cycle
// reads and a one-word-per-cycle clear sweep.
//   clk, rst (sync, active high)
//   clr_req -> busy      : clear sweep request / sweep in progress
//   wr_en, wr_index, wr_data, wr_be : byte-masked write port
//   rd_en, rd_index -> rd_valid, rd_data : pipelined read port
module global_buffer_dp #(
  parameter int WORD_SIZE = 32,
  parameter int INDX_SIZE = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_req,
  output logic                   busy,
  input  logic                   wr_en,
  input  logic [INDX_SIZE-1:0]   wr_index,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic [WORD_SIZE/8-1:0] wr_be,
  input  logic                   rd_en,
  input  logic [INDX_SIZE-1:0]   rd_index,
  output logic                   rd_valid,
  output logic [WORD_SIZE-1:0]   rd_data
);

  localparam int DEPTH = 2**INDX_SIZE;
  localparam int NB    = WORD_SIZE/8;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [INDX_SIZE-1:0]   r_clr_cnt;
  logic [WORD_SIZE-1:0]   r_mem [DEPTH];
  logic                   w_clr_we;
  logic                   w_wr_ok;
  logic                   w_rd_ok;
  logic                   w_cnt_rst;
  logic [WORD_SIZE-1:0]   w_rd_word;
  logic                   r_rd_valid;
  logic [WORD_SIZE-1:0]   r_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_rst) r_clr_cnt <= '0;
      else if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clr_we  = 1'b0;
    w_wr_ok   = 1'b0;
    w_rd_ok   = 1'b0;
    w_cnt_rst = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_clr_we = !rst;
        if (r_clr_cnt == INDX_SIZE'(DEPTH-1))
          w_next = S_IDLE;
      end
      S_IDLE: begin
        // Same-cycle accesses are still serviced when a clear is requested.
        w_wr_ok = wr_en && !rst;
        w_rd_ok = rd_en && !rst;
        if (clr_req) begin
          w_next    = S_CLEAR;
          w_cnt_rst = 1'b1;
        end
      end
      default: w_next = S_CLEAR;
    endcase
  end

  assign busy      = (r_state == S_CLEAR);
  assign w_rd_word = r_mem[rd_index];

  // Non-blocking update makes a same-index read return the old word.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_ok) begin
      for (int b = 0; b < NB; b++)
        if (wr_be[b])
          r_mem[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                 r_s1_valid;
      logic [WORD_SIZE-1:0] r_s1_data;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= '0;
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_s1_valid <= w_rd_ok;
          if (w_rd_ok) r_s1_data <= w_rd_word;
          r_rd_valid <= r_s1_valid;
          if (r_s1_valid) r_rd_data <= r_s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_valid <= 1'b0;
          r_rd_data  <= '0;
        end else begin
          r_rd_valid <= w_rd_ok;
          if (w_rd_ok) r_rd_data <= w_rd_word;
        end
      end
    end
  endgenerate

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_global_buffer_dp.sv
// tb_global_buffer_dp: directed bench for global_buffer_dp, one instance
// with RD_LAT=1 and one with RD_LAT=2 sharing all inputs.
module tb_global_buffer_dp;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        wr_en;
  logic [7:0]  wr_index;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [7:0]  rd_index;
  logic        busy1, busy2;
  logic        v1, v2;
  logic [31:0] d1, d2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  global_buffer_dp #(.WORD_SIZE(32), .INDX_SIZE(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_index(rd_index),
    .rd_valid(v1), .rd_data(d1)
  );

  global_buffer_dp #(.WORD_SIZE(32), .INDX_SIZE(8), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_index(rd_index),
    .rd_valid(v2), .rd_data(d2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_len(output int n);
    n = 0;
    while ((busy1 || busy2) && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic wr(input logic [7:0] idx, input logic [31:0] dat,
                    input logic [3:0] be);
    wr_en = 1'b1; wr_index = idx; wr_data = dat; wr_be = be;
    tick();
    wr_en = 1'b0; wr_be = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] idx,
                        input logic [31:0] exp);
    rd_en = 1'b1; rd_index = idx;
    tick();
    rd_en = 1'b0;
    chk({tag, " v1"}, 32'(v1), 32'd1);
    chk({tag, " d1"}, d1, exp);
    chk({tag, " v2 early"}, 32'(v2), 32'd0);
    tick();
    chk({tag, " v1 pulse"}, 32'(v1), 32'd0);
    chk({tag, " v2"}, 32'(v2), 32'd1);
    chk({tag, " d2"}, d2, exp);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i * 3);
  endfunction

  int n;

  initial begin
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_index = '0;
    wr_data = '0; wr_be = '0; rd_en = 1'b0; rd_index = '0;

    // 1: reset, full sweep length, cleared contents
    tick();
    rst = 1'b0;
    chk("rst busy1", 32'(busy1), 32'd1);
    chk("rst busy2", 32'(busy2), 32'd1);
    chk("rst v1", 32'(v1), 32'd0);
    chk("rst v2", 32'(v2), 32'd0);
    chk("rst d1", d1, 32'd0);
    chk("rst d2", d2, 32'd0);
    sweep_len(n);
    chk("sweep len", 32'(n), 32'd256);
    rd_chk("rd clr 77", 8'd77, 32'd0);
    rd_chk("rd clr 255", 8'd255, 32'd0);

    // 2: byte-enable merge
    wr(8'd5, 32'hDEADBEEF, 4'hF);
    wr(8'd5, 32'h11223344, 4'b0101);
    wr(8'd5, 32'hFFFFFFFF, 4'b0000);
    rd_chk("be merge", 8'd5, 32'hDE22BE44);

    // 3: read-first on same index, next read sees new word
    wr_en = 1'b1; wr_index = 8'd9; wr_data = 32'hA5A5A5A5; wr_be = 4'hF;
    rd_en = 1'b1; rd_index = 8'd9;
    tick();
    wr_en = 1'b0; wr_be = '0;
    chk("rf old d1", d1, 32'd0);
    tick();
    rd_en = 1'b0;
    chk("rf new d1", d1, 32'hA5A5A5A5);
    chk("rf old d2", d2, 32'd0);
    tick();
    chk("rf new d2", d2, 32'hA5A5A5A5);

    // 4: back-to-back reads, no bubbles
    for (int i = 0; i < 16; i++) wr(8'(i), pat(i), 4'hF);
    for (int i = 0; i < 18; i++) begin
      rd_en = (i < 16); rd_index = 8'(i);
      tick();
      if (i < 16) begin
        chk("b2b v1", 32'(v1), 32'd1);
        chk("b2b d1", d1, pat(i));
      end
      if (i >= 1 && i <= 16) begin
        chk("b2b v2", 32'(v2), 32'd1);
        chk("b2b d2", d2, pat(i - 1));
      end
    end
    rd_en = 1'b0;
    chk("b2b v2 end", 32'(v2), 32'd0);

    // 5: clear with same-cycle read, requests ignored during sweep
    clr_req = 1'b1; rd_en = 1'b1; rd_index = 8'd3;
    tick();
    clr_req = 1'b0; rd_en = 1'b0;
    chk("clr busy", 32'(busy1), 32'd1);
    chk("clr rd d1", d1, pat(3));
    tick();
    chk("clr rd v2", 32'(v2), 32'd1);
    chk("clr rd d2", d2, pat(3));
    clr_req = 1'b1; rd_en = 1'b1; rd_index = 8'd3;
    wr_en = 1'b1; wr_index = 8'd1; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    tick();
    clr_req = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wr_be = '0;
    chk("swp rd v1", 32'(v1), 32'd0);
    tick();
    chk("swp rd v2", 32'(v2), 32'd0);
    begin
      int m;
      sweep_len(m);
      chk("clr sweep len", 32'(m + 3), 32'd256);
    end
    rd_chk("swp wr drop", 8'd1, 32'd0);
    rd_chk("swp cleared", 8'd3, 32'd0);

    // 6: reset with reads in flight, then reset mid-sweep
    wr(8'd2, 32'h0BADF00D, 4'hF);
    rd_en = 1'b1; rd_index = 8'd2;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b0;
    chk("fl v1", 32'(v1), 32'd0);
    chk("fl v2", 32'(v2), 32'd0);
    chk("fl d2", d2, 32'd0);
    chk("fl busy", 32'(busy2), 32'd1);
    tick();
    chk("fl v2 late", 32'(v2), 32'd0);
    for (int i = 0; i < 98; i++) tick();
    chk("mid busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst busy", 32'(busy1), 32'd1);
    sweep_len(n);
    chk("restart len", 32'(n), 32'd256);
    rd_chk("post rst 2", 8'd2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
